scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
Parametrised, registered one-hot decoder, the next generation of the team's 3-to-8 enable decoder. It has two modes:
- Direct mode decodes a SEL_W-bit select onto 2**SEL_W outputs.
- Scan mode steps the active output round-robin through a channel mask at a prescaled rate.

Its intended use is driving Basys3 seven-segment anodes, LED banks and chip-selects from one generic block.

Parameters:
SEL_W, 3, select/index width; N_OUT = 2**SEL_W outputs; legal range 1..5.
PRESCALE, 100000, clk cycles per scan step; legal range >= 1; 1 means step every cycle.
ACTIVE_LOW, 0, 1 = outputs inverted (active output driven 0, inactive outputs driven 1), for Basys3 anodes.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  global enable; low forces all outputs inactive and freezes scan state
mode  in  1  0 = direct decode, 1 = auto scan
sel  in  SEL_W  select index, used in direct mode only
chan_mask  in  N_OUT  scan mode: 1 = channel takes part in the rotation
dout  out  N_OUT  registered one-hot (one-cold if ACTIVE_LOW) decoded output
idx  out  SEL_W  registered index currently driven
step  out  1  one-cycle pulse, registered with idx, when scan advances

Behaviour:
- Reset: rst_n sampled low at clk edge gives:
  - dout = all inactive (0s, or all 1s if ACTIVE_LOW);
  - idx = 0, step = 0;
  - prescaler count = 0.
  Reset mid-scan aborts immediately; no partial step pulse.
- Polarity: all behaviour below is stated in active-high terms; ACTIVE_LOW inverts dout only.
- Direct mode (mode=0), latency 1 cycle:
  - en=1: idx <= sel and dout <= onehot(sel).
  - en=0: dout <= inactive and idx holds.
  - step = 0 always.
  - Prescaler held at 0.
- Scan mode (mode=1):
  - Prescaler counts 0..PRESCALE-1 while en=1. Its width is max(1, clog2(PRESCALE)).
  - At terminal count the prescaler returns to 0, idx <= next_idx, and step <= 1 for exactly that cycle.
  - next_idx: first index j in idx+1, idx+2, ... with chan_mask[j]=1, wrapping modulo N_OUT and checking idx itself last. If only idx is set, idx stays unchanged but step still pulses.
  - dout <= onehot(idx_next_registered) only if chan_mask of that index = 1, else inactive.
  - chan_mask is sampled every cycle. Clearing the bit of the current idx blanks dout on the next cycle without waiting for a step.
  - chan_mask all zero: dout inactive, idx holds, step = 0, prescaler keeps counting.
- en=0 in scan mode: prescaler and idx freeze, dout inactive, step = 0. When en returns, counting resumes from the frozen value.
- Mode change, detected as mode differing from the previous cycle's registered mode:
  - Prescaler clears to 0.
  - Direct->scan: scanning starts from the current idx, and the first step occurs PRESCALE cycles later.
  - Scan->direct: sel takes over next cycle.
- Simultaneous events: reset dominates everything; then en=0; then mode change; then terminal count.
- Invariant: at most one bit of dout is active every cycle.

Decomposition:
- Shared package (decoder_pkg): mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1, and a clog2-with-min-1 width function. Reused by future display drivers.
- One sub-module: rr_next_index, parametrised by SEL_W. Inputs are cur_idx and mask; outputs are nxt_idx and any_set. Purely combinational, wrap-around priority search.
- All registers stay in scan_decoder.

Test Plan:
1. Reset then direct: SEL_W=3, ACTIVE_LOW=0, rst_n=0 for 2 cycles, then mode=0, en=1, sel=5 -> during reset dout=8'h00, idx=0; one cycle after sel=5, dout=8'h20, idx=5. Sweep sel 0..7 -> dout = 1<<sel, each with 1-cycle latency; en=0 -> dout=8'h00 next cycle.
2. Full scan: PRESCALE=4, mode=1, en=1, chan_mask=8'hFF, start idx=0 -> idx advances 0,1,...,7,0 every 4 cycles, with step high exactly 1 cycle per advance; dout tracks 1<<idx.
3. Masked scan with wrap: chan_mask=8'b1000_0101, idx=0 -> sequence 0,2,7,0,2; dout 8'h01, 8'h04, 8'h80; masked channels never active.
4. Corner masks: chan_mask=8'h10 with idx=4 -> idx stays 4, step pulses every 4 cycles. Then chan_mask=0 -> dout=8'h00 next cycle and step stays 0.
5. Freeze and mode change: en=0 for 10 cycles mid-count -> idx and prescaler unchanged, dout=0; after re-enable the step lands at the remaining count. Then toggle mode 1->0->1 -> first step exactly PRESCALE cycles after re-entry.
6. ACTIVE_LOW=1, PRESCALE=1, mode=1, chan_mask=8'hFF -> dout = ~(1<<idx) and idx advances every cycle. Assert rst_n=0 mid-scan -> next cycle dout=8'hFF, idx=0, step=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder family: mode encodings and a
// width helper that never returns zero.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // clog2 with a floor of 1, so a counter always has at least one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_next_index.sv
// Round-robin successor search: the first set mask bit after cur_idx,
// wrapping, with cur_idx itself checked last.
module rr_next_index #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      cur_idx,
  input  logic [(1<<SEL_W)-1:0] mask,
  output logic [SEL_W-1:0]      nxt_idx,
  output logic                  any_set
);
  localparam int N_OUT = 1 << SEL_W;

  // Offsets 1..N_OUT; index arithmetic wraps naturally at SEL_W bits,
  // so offset N_OUT lands back on cur_idx.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] j;
    found   = 1'b0;
    nxt_idx = cur_idx;
    j       = cur_idx;
    for (int k = 1; k <= N_OUT; k++) begin
      j = cur_idx + SEL_W'(k);
      if (!found && mask[j]) begin
        nxt_idx = j;
        found   = 1'b1;
      end
    end
    any_set = |mask;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct select and prescaled
// round-robin scan modes; optional active-low output polarity.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int PRESCALE   = 100000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [(1<<SEL_W)-1:0] chan_mask,
  output logic [(1<<SEL_W)-1:0] dout,
  output logic [SEL_W-1:0]      idx,
  output logic                  step
);
  localparam int N_OUT = 1 << SEL_W;
  localparam int PW    = clog2_min1(PRESCALE);
  localparam logic [PW-1:0]    TC    = PW'(PRESCALE - 1);
  // XOR mask that turns an active-high pattern into output polarity.
  localparam logic [N_OUT-1:0] INACT = {N_OUT{ACTIVE_LOW}};

  logic [N_OUT-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             step_q, step_d;
  logic             mode_q;

  logic [SEL_W-1:0] nxt_idx;
  logic             any_set;

  rr_next_index #(.SEL_W(SEL_W)) u_rr (
    .cur_idx (idx_q),
    .mask    (chan_mask),
    .nxt_idx (nxt_idx),
    .any_set (any_set)
  );

  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
    return {{(N_OUT-1){1'b0}}, 1'b1} << i;
  endfunction

  // Next-state: en=0 wins, then direct decode, then scan with mode-change
  // restart taking priority over terminal count.
  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    step_d = 1'b0;
    dout_d = INACT;
    if (!en) begin
      // Scan freezes; direct keeps the prescaler parked at zero.
      if (mode == MODE_DIRECT) pre_d = '0;
    end else if (mode == MODE_DIRECT) begin
      idx_d  = sel;
      dout_d = onehot(sel) ^ INACT;
      pre_d  = '0;
    end else begin
      if (mode != mode_q) begin
        pre_d = '0;
      end else if (pre_q == TC) begin
        pre_d = '0;
        if (any_set) begin
          idx_d  = nxt_idx;
          step_d = 1'b1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
      // Mask sampled every cycle so a cleared channel blanks at once.
      if (chan_mask[idx_d]) dout_d = onehot(idx_d) ^ INACT;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= INACT;
      idx_q  <= '0;
      pre_q  <= '0;
      step_q <= 1'b0;
      mode_q <= MODE_DIRECT;
    end else begin
      dout_q <= dout_d;
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      step_q <= step_d;
      mode_q <= mode;
    end
  end

  assign dout = dout_q;
  assign idx  = idx_q;
  assign step = step_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench: DUT a (PRESCALE=4, active high) and DUT b
// (PRESCALE=1, active low) share one clock.
module tb_scan_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       a_rst_n, a_en, a_mode;
  logic [2:0] a_sel;
  logic [7:0] a_mask, a_dout;
  logic [2:0] a_idx;
  logic       a_step;

  logic       b_rst_n, b_en, b_mode;
  logic [2:0] b_sel;
  logic [7:0] b_mask, b_dout;
  logic [2:0] b_idx;
  logic       b_step;

  scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .mode(a_mode), .sel(a_sel),
    .chan_mask(a_mask), .dout(a_dout), .idx(a_idx), .step(a_step)
  );

  scan_decoder #(.SEL_W(3), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .mode(b_mode), .sel(b_sel),
    .chan_mask(b_mask), .dout(b_dout), .idx(b_idx), .step(b_step)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 0; a_en = 1; a_mode = 0; a_sel = 3'd5; a_mask = 8'h00;
    b_rst_n = 0; b_en = 0; b_mode = 0; b_sel = 3'd0; b_mask = 8'h00;
    tick(); tick();
    n_cmp++; if (a_dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", a_dout); end
    n_cmp++; if (a_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", a_idx); end
    n_cmp++; if (a_step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %b want 0", a_step); end
    n_cmp++; if (b_dout !== 8'hFF) begin n_err++; $display("FAIL reset_dout_al: got %h want ff", b_dout); end
  endtask

  task automatic test_direct();
    a_rst_n = 1; a_sel = 3'd5;
    tick();
    n_cmp++; if (a_dout !== 8'h20 || a_idx !== 3'd5) begin n_err++; $display("FAIL direct_sel5: got %h/%0d want 20/5", a_dout, a_idx); end
    for (int s = 0; s < 8; s++) begin
      logic [7:0] e;
      a_sel = 3'(s);
      e = 8'h01 << s;
      tick();
      n_cmp++; if (a_dout !== e || a_idx !== 3'(s) || a_step !== 1'b0) begin
        n_err++; $display("FAIL direct_sweep%0d: got %h/%0d/%b want %h/%0d/0", s, a_dout, a_idx, a_step, e, s);
      end
    end
    a_en = 0; a_sel = 3'd2;
    tick();
    n_cmp++; if (a_dout !== 8'h00 || a_idx !== 3'd7) begin n_err++; $display("FAIL direct_en0: got %h/%0d want 00/7", a_dout, a_idx); end
  endtask

  task automatic test_full_scan();
    a_en = 1; a_sel = 3'd0;
    tick();
    a_mode = 1; a_mask = 8'hFF;
    tick();
    n_cmp++; if (a_dout !== 8'h01 || a_idx !== 3'd0 || a_step !== 1'b0) begin
      n_err++; $display("FAIL scan_entry: got %h/%0d/%b want 01/0/0", a_dout, a_idx, a_step);
    end
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] ei;
      ei = 3'(k);
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (c < 4) begin
          n_cmp++; if (a_step !== 1'b0 || a_idx !== 3'(k - 1)) begin
            n_err++; $display("FAIL full_hold%0d_%0d: got %0d/%b want %0d/0", k, c, a_idx, a_step, k - 1);
          end
        end else begin
          n_cmp++; if (a_step !== 1'b1 || a_idx !== ei || a_dout !== (8'h01 << ei)) begin
            n_err++; $display("FAIL full_step%0d: got %0d/%b/%h want %0d/1/%h", k, a_idx, a_step, a_dout, ei, 8'h01 << ei);
          end
        end
      end
    end
  endtask

  task automatic test_masked_scan();
    logic [2:0] seq [4];
    seq = '{3'd2, 3'd7, 3'd0, 3'd2};
    a_mask = 8'b1000_0101;
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        n_cmp++; if ((a_dout & ~a_mask) !== 8'h00) begin n_err++; $display("FAIL masked_leak%0d: got %h", k, a_dout); end
      end
      n_cmp++; if (a_step !== 1'b1 || a_idx !== seq[k] || a_dout !== (8'h01 << seq[k])) begin
        n_err++; $display("FAIL masked_step%0d: got %0d/%b/%h want %0d/1/%h", k, a_idx, a_step, a_dout, seq[k], 8'h01 << seq[k]);
      end
    end
  endtask

  task automatic test_corner_masks();
    a_mask = 8'h10;
    tick();
    n_cmp++; if (a_dout !== 8'h00) begin n_err++; $display("FAIL corner_blank: got %h want 00", a_dout); end
    tick(); tick(); tick();
    n_cmp++; if (a_idx !== 3'd4 || a_step !== 1'b1 || a_dout !== 8'h10) begin
      n_err++; $display("FAIL corner_to4: got %0d/%b/%h want 4/1/10", a_idx, a_step, a_dout);
    end
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        n_cmp++; if (a_idx !== 3'd4 || a_step !== (c == 4) || a_dout !== 8'h10) begin
          n_err++; $display("FAIL corner_single%0d_%0d: got %0d/%b/%h want 4/%b/10", r, c, a_idx, a_step, a_dout, c == 4);
        end
      end
    end
    a_mask = 8'h00;
    for (int c = 0; c < 9; c++) begin
      tick();
      n_cmp++; if (a_dout !== 8'h00 || a_step !== 1'b0 || a_idx !== 3'd4) begin
        n_err++; $display("FAIL corner_empty%0d: got %h/%b/%0d want 00/0/4", c, a_dout, a_step, a_idx);
      end
    end
  endtask

  task automatic test_freeze_mode();
    bit seen;
    a_mask = 8'hFF;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (a_step === 1'b1) seen = 1;
    end
    n_cmp++; if (!seen || a_idx !== 3'd5) begin n_err++; $display("FAIL freeze_sync: seen %b idx %0d want 1/5", seen, a_idx); end
    tick(); tick();
    a_en = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (a_idx !== 3'd5 || a_dout !== 8'h00 || a_step !== 1'b0) begin
        n_err++; $display("FAIL freeze_hold%0d: got %0d/%h/%b want 5/00/0", c, a_idx, a_dout, a_step);
      end
    end
    a_en = 1;
    tick();
    n_cmp++; if (a_step !== 1'b0 || a_dout !== 8'h20) begin n_err++; $display("FAIL freeze_resume1: got %b/%h want 0/20", a_step, a_dout); end
    tick();
    n_cmp++; if (a_step !== 1'b1 || a_idx !== 3'd6 || a_dout !== 8'h40) begin
      n_err++; $display("FAIL freeze_resume2: got %b/%0d/%h want 1/6/40", a_step, a_idx, a_dout);
    end
    tick();
    a_mode = 0; a_sel = 3'd3;
    tick();
    n_cmp++; if (a_idx !== 3'd3 || a_dout !== 8'h08 || a_step !== 1'b0) begin
      n_err++; $display("FAIL mode_to_direct: got %0d/%h/%b want 3/08/0", a_idx, a_dout, a_step);
    end
    a_mode = 1;
    tick();
    n_cmp++; if (a_idx !== 3'd3 || a_dout !== 8'h08 || a_step !== 1'b0) begin
      n_err++; $display("FAIL mode_to_scan: got %0d/%h/%b want 3/08/0", a_idx, a_dout, a_step);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++; if (a_step !== (c == 4) || a_idx !== ((c == 4) ? 3'd4 : 3'd3)) begin
        n_err++; $display("FAIL mode_first_step%0d: got %b/%0d want %b/%0d", c, a_step, a_idx, c == 4, (c == 4) ? 4 : 3);
      end
    end
  endtask

  task automatic test_active_low();
    b_rst_n = 1; b_en = 1; b_mode = 1; b_mask = 8'hFF;
    tick();
    n_cmp++; if (b_dout !== 8'hFE || b_idx !== 3'd0 || b_step !== 1'b0) begin
      n_err++; $display("FAIL al_entry: got %h/%0d/%b want fe/0/0", b_dout, b_idx, b_step);
    end
    for (int k = 1; k <= 10; k++) begin
      logic [2:0] ei;
      logic [7:0] e;
      ei = 3'(k);
      e = ~(8'h01 << ei);
      tick();
      n_cmp++; if (b_dout !== e || b_idx !== ei || b_step !== 1'b1) begin
        n_err++; $display("FAIL al_step%0d: got %h/%0d/%b want %h/%0d/1", k, b_dout, b_idx, b_step, e, ei);
      end
    end
    b_rst_n = 0;
    tick();
    n_cmp++; if (b_dout !== 8'hFF || b_idx !== 3'd0 || b_step !== 1'b0) begin
      n_err++; $display("FAIL al_reset: got %h/%0d/%b want ff/0/0", b_dout, b_idx, b_step);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_full_scan();
    test_masked_scan();
    test_corner_masks();
    test_freeze_mode();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
